// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment scan scheduler: segment patterns
// (a..g in bits 0..6, dp in bit 7) and the per-slot scan state.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (a..g = bits 0..6, active-high).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (hex)
      4'h0: seg = SEG_0[6:0];
      4'h1: seg = SEG_1[6:0];
      4'h2: seg = SEG_2[6:0];
      4'h3: seg = SEG_3[6:0];
      4'h4: seg = SEG_4[6:0];
      4'h5: seg = SEG_5[6:0];
      4'h6: seg = SEG_6[6:0];
      4'h7: seg = SEG_7[6:0];
      4'h8: seg = SEG_8[6:0];
      4'h9: seg = SEG_9[6:0];
      4'hA: seg = SEG_A[6:0];
      4'hB: seg = SEG_B[6:0];
      4'hC: seg = SEG_C[6:0];
      4'hD: seg = SEG_D[6:0];
      4'hE: seg = SEG_E[6:0];
      4'hF: seg = SEG_F[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexed scan controller for a common-select seven-segment display,
// with per-slot anti-ghost blanking and per-digit flash sequences.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 5,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 64,
  parameter int BLINK_DIV     = 24,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   flash_req,
  output logic [NUM_DIGITS-1:0]   SEG_SEL,
  output logic [7:0]              SEG_DATA,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FL_W  = $clog2(FLASH_TOGGLES + 1);
  localparam int FRM_W = $clog2(BLINK_DIV + 1);
  localparam scan_state_t ENTRY_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  scan_state_t      state_reg;
  logic [FRM_W-1:0] frame_cnt_reg;

  logic [3:0] lat_val_reg;
  logic       lat_vis_reg;
  logic       lat_dp_reg;

  logic [3:0]            val_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] flash_dark;

  logic                  slot_entry;
  logic                  slot_end;
  logic                  frame_wrap;
  logic                  blink_tick;
  logic                  entry_vis;
  logic [3:0]            view_val;
  logic                  view_vis;
  logic                  view_dp;
  logic [6:0]            view_seg;
  logic [NUM_DIGITS-1:0] sel_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_val
      assign val_arr[gi] = digit_val[4*gi +: 4];
    end
  endgenerate

  assign slot_entry = (cnt_reg == '0);
  assign slot_end   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  // Tick on the wrap edge itself so the next slot-0 latch already sees the
  // updated flash count.
  assign blink_tick = frame_wrap && (frame_cnt_reg == FRM_W'(BLINK_DIV - 1));

  assign entry_vis = digit_en[idx_reg] && !flash_dark[idx_reg];

  // In the entry cycle the latch has not been written yet; use the live view.
  assign view_val   = slot_entry ? val_arr[idx_reg]  : lat_val_reg;
  assign view_vis   = slot_entry ? entry_vis         : lat_vis_reg;
  assign view_dp    = slot_entry ? dp_mask[idx_reg]  : lat_dp_reg;
  assign sel_onehot = NUM_DIGITS'(1) << idx_reg;

  seg7_decode u_decode (
    .hex(view_val),
    .seg(view_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      state_reg  <= ENTRY_STATE;
      SEG_SEL    <= '0;
      SEG_DATA   <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_reg   <= '0;
        idx_reg   <= frame_wrap ? '0 : idx_reg + IDX_W'(1);
        state_reg <= ENTRY_STATE;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (int'(cnt_reg) + 1 >= BLANK_CYCLES) begin
          state_reg <= DRIVE;
        end
      end

      if (state_reg == DRIVE && view_vis) begin
        SEG_SEL  <= sel_onehot;
        SEG_DATA <= {view_dp, view_seg};
      end else begin
        SEG_SEL  <= '0;
        SEG_DATA <= SEG_BLANK;
      end

      frame_done <= frame_wrap;
    end
  end

  // Slot contents are frozen at entry so mid-slot input changes cannot tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_val_reg <= '0;
      lat_vis_reg <= 1'b0;
      lat_dp_reg  <= 1'b0;
    end else if (slot_entry) begin
      lat_val_reg <= val_arr[idx_reg];
      lat_vis_reg <= entry_vis;
      lat_dp_reg  <= dp_mask[idx_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (frame_wrap) begin
      if (frame_cnt_reg == FRM_W'(BLINK_DIV - 1)) begin
        frame_cnt_reg <= '0;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + FRM_W'(1);
      end
    end
  end

  // Odd remaining half-periods are the dark ones, so the sequence ends lit.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_flash
      logic [FL_W-1:0] flash_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          flash_cnt_reg <= '0;
        end else if (flash_req[gi]) begin
          flash_cnt_reg <= FL_W'(FLASH_TOGGLES);
        end else if (blink_tick && flash_cnt_reg != '0) begin
          flash_cnt_reg <= flash_cnt_reg - FL_W'(1);
        end
      end

      assign flash_dark[gi] = (flash_cnt_reg != '0) && flash_cnt_reg[0];
    end
  endgenerate

endmodule
